axi4_to_axi3_rd_splitter: RTL



---
 rtl/axi4_to_axi3_rd_splitter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_to_axi3_rd_splitter.sv
// AXI4 -> AXI3 read splitter.
// Takes one AXI4 read burst of up to 256 beats and re-issues it as a run of
// sub-bursts of at most C_MAX_BEATS beats. Read data passes straight through.
// Upstream RLAST is raised only on the final beat of the final sub-burst.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both 1. VALID never waits for READY. While
// VALID=1 and READY=0, the payload is held stable.
module axi4_to_axi3_rd_splitter #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ID_WIDTH   = 6,
    parameter int C_MAX_BEATS  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic [1:0]              S_AXI_ARLOCK,
    input  logic [3:0]              S_AXI_ARCACHE,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic [3:0]              S_AXI_ARQOS,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [C_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [C_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [3:0]              M_AXI_ARLEN,
    output logic [2:0]              M_AXI_ARSIZE,
    output logic [1:0]              M_AXI_ARBURST,
    output logic [1:0]              M_AXI_ARLOCK,
    output logic [3:0]              M_AXI_ARCACHE,
    output logic [2:0]              M_AXI_ARPROT,
    output logic [3:0]              M_AXI_ARQOS,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [C_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RLAST,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic [1:0]              dbg_state
);

    localparam int         SHIFT       = $clog2(C_MAX_BEATS);
    localparam logic [8:0] MAX_BEATS_9 = 9'(C_MAX_BEATS);
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state;
    logic [C_ID_WIDTH-1:0]   id_r;
    logic [C_ADDR_WIDTH-1:0] addr_r;
    logic [3:0]              len_r;
    logic [2:0]              size_r;
    logic [1:0]              burst_r;
    logic [1:0]              lock_r;
    logic [3:0]              cache_r;
    logic [2:0]              prot_r;
    logic [3:0]              qos_r;
    logic [8:0]              beats_left;
    logic [8:0]              n_sub;
    logic [8:0]              sub_issued;
    logic [8:0]              sub_done;
    logic                    ar_ready_r;
    logic                    ar_valid_r;

    logic [4:0]              sub_beats;
    logic [C_ADDR_WIDTH-1:0] addr_step;
    logic                    r_hs;
    logic                    last_sub_r;
    logic                    final_r;
    logic                    m_ar_hs;
    logic                    last_ar;

    // Beat count of the sub-burst now on offer. Non-INCR bursts go out whole.
    always_comb begin
        sub_beats = 5'd0;
        if (burst_r != BURST_INCR)
            sub_beats = {1'b0, len_r} + 5'd1;
        else if (beats_left > MAX_BEATS_9)
            sub_beats = 5'(C_MAX_BEATS);
        else
            sub_beats = beats_left[4:0];
    end

    assign addr_step  = C_ADDR_WIDTH'(sub_beats) << size_r;
    assign r_hs       = M_AXI_RVALID & S_AXI_RREADY;
    assign last_sub_r = (sub_done == n_sub - 9'd1);
    assign final_r    = r_hs & M_AXI_RLAST & last_sub_r;
    assign m_ar_hs    = ar_valid_r & M_AXI_ARREADY;
    assign last_ar    = (sub_issued == n_sub - 9'd1);

    assign S_AXI_ARREADY = ar_ready_r;
    assign M_AXI_ARVALID = ar_valid_r;
    assign M_AXI_ARID    = id_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_ARLEN   = 4'(sub_beats - 5'd1);
    assign M_AXI_ARSIZE  = size_r;
    assign M_AXI_ARBURST = burst_r;
    assign M_AXI_ARLOCK  = lock_r;
    assign M_AXI_ARCACHE = cache_r;
    assign M_AXI_ARPROT  = prot_r;
    assign M_AXI_ARQOS   = qos_r;
    assign dbg_state     = state;

    // Read data passes through with no latency. Only RLAST is masked.
    assign S_AXI_RVALID = M_AXI_RVALID;
    assign M_AXI_RREADY = S_AXI_RREADY;
    assign S_AXI_RID    = M_AXI_RID;
    assign S_AXI_RDATA  = M_AXI_RDATA;
    assign S_AXI_RRESP  = M_AXI_RRESP;
    assign S_AXI_RLAST  = M_AXI_RLAST & last_sub_r;

    // Request FSM. sub_done counts completed sub-bursts in any state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            id_r       <= '0;
            addr_r     <= '0;
            len_r      <= '0;
            size_r     <= '0;
            burst_r    <= '0;
            lock_r     <= '0;
            cache_r    <= '0;
            prot_r     <= '0;
            qos_r      <= '0;
            beats_left <= '0;
            n_sub      <= '0;
            sub_issued <= '0;
            sub_done   <= '0;
            ar_ready_r <= 1'b0;
            ar_valid_r <= 1'b0;
        end else begin
            if (r_hs && M_AXI_RLAST)
                sub_done <= sub_done + 9'd1;
            case (state)
                IDLE: begin
                    ar_ready_r <= 1'b1;
                    if (S_AXI_ARVALID && ar_ready_r) begin
                        id_r       <= S_AXI_ARID;
                        addr_r     <= S_AXI_ARADDR;
                        len_r      <= S_AXI_ARLEN[3:0];
                        size_r     <= S_AXI_ARSIZE;
                        burst_r    <= S_AXI_ARBURST;
                        lock_r     <= S_AXI_ARLOCK;
                        cache_r    <= S_AXI_ARCACHE;
                        prot_r     <= S_AXI_ARPROT;
                        qos_r      <= S_AXI_ARQOS;
                        beats_left <= {1'b0, S_AXI_ARLEN} + 9'd1;
                        n_sub      <= (S_AXI_ARBURST == BURST_INCR) ?
                                      (({1'b0, S_AXI_ARLEN} >> SHIFT) + 9'd1) : 9'd1;
                        sub_issued <= '0;
                        sub_done   <= '0;
                        ar_ready_r <= 1'b0;
                        ar_valid_r <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ar_hs) begin
                        addr_r     <= addr_r + addr_step;
                        beats_left <= beats_left - 9'(sub_beats);
                        sub_issued <= sub_issued + 9'd1;
                        if (last_ar) begin
                            ar_valid_r <= 1'b0;
                            if (final_r) begin
                                ar_ready_r <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (final_r) begin
                        ar_ready_r <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
